// File: rtl/writeback_stage.sv
// Writeback stage of the rv32i pipeline: one-entry holding register, load formatting,
// register file write port, forwarding view and retired-instruction counter.
module writeback_stage #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned REG_ADDR_WIDTH = 5,
    parameter int unsigned INSTRET_WIDTH  = 64
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      mem_valid,
    output logic                      wb_ready,
    input  logic                      mem_reg_write,
    input  logic [REG_ADDR_WIDTH-1:0] mem_rd_addr,
    input  logic [1:0]                mem_wb_sel,
    input  logic [2:0]                mem_funct3,
    input  logic [DATA_WIDTH-1:0]     mem_alu_result,
    input  logic [DATA_WIDTH-1:0]     mem_load_data,
    input  logic [DATA_WIDTH-1:0]     mem_pc,
    input  logic [DATA_WIDTH-1:0]     mem_imm,
    input  logic                      hold,
    output logic                      write_enable,
    output logic [REG_ADDR_WIDTH-1:0] write_addr,
    output logic [DATA_WIDTH-1:0]     write_data,
    output logic                      fwd_valid,
    output logic [INSTRET_WIDTH-1:0]  instret
);

    typedef enum logic [1:0] {
        SelAlu  = 2'b00,
        SelLoad = 2'b01,
        SelPc4  = 2'b10,
        SelImm  = 2'b11
    } wb_sel_e;

    logic                      valid_q;
    logic                      reg_write_q;
    logic [REG_ADDR_WIDTH-1:0] rd_q;
    logic [DATA_WIDTH-1:0]     result_q;
    logic [INSTRET_WIDTH-1:0]  instret_q;

    logic                      commit;
    logic                      capture;
    logic [1:0]                byte_addr;
    logic [7:0]                load_byte;
    logic [15:0]               load_half;
    logic [DATA_WIDTH-1:0]     load_fmt;
    logic [DATA_WIDTH-1:0]     result_d;

    assign commit   = valid_q & ~hold;
    assign wb_ready = ~valid_q | ~hold;
    assign capture  = mem_valid & wb_ready;

    assign byte_addr = mem_alu_result[1:0];

    // Byte lane select; halfword loads ignore the low address bit.
    always_comb begin
        load_byte = 8'h00;
        unique case (byte_addr)
            2'd0: load_byte = mem_load_data[7:0];
            2'd1: load_byte = mem_load_data[15:8];
            2'd2: load_byte = mem_load_data[23:16];
            2'd3: load_byte = mem_load_data[31:24];
            default: load_byte = 8'h00;
        endcase
        load_half = byte_addr[1] ? mem_load_data[31:16] : mem_load_data[15:0];
    end

    always_comb begin
        load_fmt = mem_load_data;
        case (mem_funct3)
            3'b000:  load_fmt = {{(DATA_WIDTH-8){load_byte[7]}}, load_byte};
            3'b001:  load_fmt = {{(DATA_WIDTH-16){load_half[15]}}, load_half};
            3'b100:  load_fmt = {{(DATA_WIDTH-8){1'b0}}, load_byte};
            3'b101:  load_fmt = {{(DATA_WIDTH-16){1'b0}}, load_half};
            default: load_fmt = mem_load_data;
        endcase
    end

    always_comb begin
        result_d = mem_alu_result;
        unique case (wb_sel_e'(mem_wb_sel))
            SelAlu:  result_d = mem_alu_result;
            SelLoad: result_d = load_fmt;
            SelPc4:  result_d = mem_pc + DATA_WIDTH'(4);
            SelImm:  result_d = mem_imm;
            default: result_d = mem_alu_result;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            valid_q     <= 1'b0;
            reg_write_q <= 1'b0;
            rd_q        <= '0;
            result_q    <= '0;
        end else if (capture) begin
            valid_q     <= 1'b1;
            reg_write_q <= mem_reg_write;
            rd_q        <= mem_rd_addr;
            result_q    <= result_d;
        end else if (commit) begin
            valid_q     <= 1'b0;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            instret_q <= '0;
        end else if (commit) begin
            instret_q <= instret_q + INSTRET_WIDTH'(1);
        end
    end

    // x0 still retires but never reaches the register file.
    assign write_enable = commit & reg_write_q & (rd_q != '0);
    assign fwd_valid    = write_enable;
    assign write_addr   = rd_q;
    assign write_data   = result_q;
    assign instret      = instret_q;

endmodule

// File: tb/tb_writeback_stage.sv
// Self-checking bench for writeback_stage: directed cases plus randomized traffic
// compared against a queue-based reference model.
module tb_writeback_stage;

    logic        CLK = 1'b0;
    logic        RST;
    logic        mem_valid;
    logic        wb_ready;
    logic        mem_reg_write;
    logic [4:0]  mem_rd_addr;
    logic [1:0]  mem_wb_sel;
    logic [2:0]  mem_funct3;
    logic [31:0] mem_alu_result;
    logic [31:0] mem_load_data;
    logic [31:0] mem_pc;
    logic [31:0] mem_imm;
    logic        hold;
    logic        write_enable;
    logic [4:0]  write_addr;
    logic [31:0] write_data;
    logic        fwd_valid;
    logic [63:0] instret;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 CLK = ~CLK;

    writeback_stage #(
        .DATA_WIDTH    (32),
        .REG_ADDR_WIDTH(5),
        .INSTRET_WIDTH (64)
    ) dut (
        .CLK           (CLK),
        .RST           (RST),
        .mem_valid     (mem_valid),
        .wb_ready      (wb_ready),
        .mem_reg_write (mem_reg_write),
        .mem_rd_addr   (mem_rd_addr),
        .mem_wb_sel    (mem_wb_sel),
        .mem_funct3    (mem_funct3),
        .mem_alu_result(mem_alu_result),
        .mem_load_data (mem_load_data),
        .mem_pc        (mem_pc),
        .mem_imm       (mem_imm),
        .hold          (hold),
        .write_enable  (write_enable),
        .write_addr    (write_addr),
        .write_data    (write_data),
        .fwd_valid     (fwd_valid),
        .instret       (instret)
    );

    // Reference model: pending instructions as a queue, plus the last captured fields
    typedef struct {
        logic        rw;
        logic [4:0]  rd;
        logic [31:0] res;
    } ent_t;

    ent_t        pend[$];
    logic [4:0]  m_rd;
    logic [31:0] m_res;
    logic [63:0] m_cnt;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_result(input logic [1:0] sel, input logic [2:0] f3,
                                               input logic [31:0] alu, input logic [31:0] ld,
                                               input logic [31:0] pc, input logic [31:0] imm);
        logic [31:0] v;
        int unsigned a;
        a = alu[1:0];
        case (sel)
            2'd0: v = alu;
            2'd2: v = pc + 32'd4;
            2'd3: v = imm;
            default: begin
                case (f3)
                    3'd0, 3'd4: begin
                        v = (ld >> (8 * a)) & 32'hFF;
                        if (f3 == 3'd0 && v >= 32'd128) v = v - 32'd256;
                    end
                    3'd1, 3'd5: begin
                        v = (ld >> (16 * (a / 2))) & 32'hFFFF;
                        if (f3 == 3'd1 && v >= 32'd32768) v = v - 32'd65536;
                    end
                    default: v = ld;
                endcase
            end
        endcase
        return v;
    endfunction

    task automatic model_reset();
        pend.delete();
        m_rd  = '0;
        m_res = '0;
        m_cnt = '0;
    endtask

    task automatic check_outputs();
        logic exp_we;
        logic exp_rdy;
        exp_we  = (pend.size() != 0) && !hold && pend[0].rw && (pend[0].rd != 0);
        exp_rdy = (pend.size() == 0) || !hold;
        check("write_enable", 64'(write_enable), 64'(exp_we));
        check("fwd_valid", 64'(fwd_valid), 64'(exp_we));
        check("wb_ready", 64'(wb_ready), 64'(exp_rdy));
        check("write_addr", 64'(write_addr), 64'(m_rd));
        check("write_data", 64'(write_data), 64'(m_res));
        check("instret", instret, m_cnt);
    endtask

    // Check at the falling edge, then advance model and DUT across one rising edge.
    task automatic tick();
        logic commit;
        logic ready;
        ent_t e;
        @(negedge CLK);
        check_outputs();
        commit = (pend.size() != 0) && !hold;
        ready  = (pend.size() == 0) || !hold;
        @(posedge CLK);
        if (commit) begin
            void'(pend.pop_front());
            m_cnt = m_cnt + 64'd1;
        end
        if (mem_valid && ready) begin
            e.rw  = mem_reg_write;
            e.rd  = mem_rd_addr;
            e.res = ref_result(mem_wb_sel, mem_funct3, mem_alu_result, mem_load_data,
                               mem_pc, mem_imm);
            pend.push_back(e);
            m_rd  = e.rd;
            m_res = e.res;
        end
        #1;
    endtask

    task automatic drive(input logic v, input logic rw, input logic [4:0] rd,
                         input logic [1:0] sel, input logic [2:0] f3, input logic [31:0] alu,
                         input logic [31:0] ld, input logic [31:0] pc, input logic [31:0] imm);
        mem_valid      = v;
        mem_reg_write  = rw;
        mem_rd_addr    = rd;
        mem_wb_sel     = sel;
        mem_funct3     = f3;
        mem_alu_result = alu;
        mem_load_data  = ld;
        mem_pc         = pc;
        mem_imm        = imm;
    endtask

    task automatic load_case(input string tag, input logic [2:0] f3, input logic [1:0] a,
                             input logic [31:0] exp);
        drive(1'b1, 1'b1, 5'd9, 2'b01, f3, {30'h0000_1000, a}, 32'h80FF7F01, 32'h0, 32'h0);
        tick();
        check(tag, 64'(write_data), 64'(exp));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [63:0] cnt_snap;
        RST  = 1'b1;
        hold = 1'b0;
        drive(1'b0, 1'b0, 5'd0, 2'b00, 3'd0, 32'h0, 32'h0, 32'h0, 32'h0);
        model_reset();

        // Reset then idle
        repeat (2) @(posedge CLK);
        #1;
        check("rst_we", 64'(write_enable), 64'd0);
        check("rst_wdata", 64'(write_data), 64'd0);
        check("rst_waddr", 64'(write_addr), 64'd0);
        check("rst_ready", 64'(wb_ready), 64'd1);
        check("rst_instret", instret, 64'd0);
        RST = 1'b0;
        repeat (5) tick();
        check("idle_instret", instret, 64'd0);

        // ALU result to rd=5, then the same to x0
        drive(1'b1, 1'b1, 5'd5, 2'b00, 3'd0, 32'h12345678, 32'h0, 32'h0, 32'h0);
        tick();
        check("alu_we", 64'(write_enable), 64'd1);
        check("alu_addr", 64'(write_addr), 64'd5);
        check("alu_data", 64'(write_data), 64'h12345678);
        drive(1'b1, 1'b1, 5'd0, 2'b00, 3'd0, 32'h12345678, 32'h0, 32'h0, 32'h0);
        tick();
        check("alu_instret1", instret, 64'd1);
        check("x0_we", 64'(write_enable), 64'd0);
        drive(1'b0, 1'b0, 5'd0, 2'b00, 3'd0, 32'h0, 32'h0, 32'h0, 32'h0);
        tick();
        check("x0_instret2", instret, 64'd2);

        // Load formatting
        load_case("lb_a3", 3'b000, 2'd3, 32'hFFFFFF80);
        load_case("lbu_a3", 3'b100, 2'd3, 32'h00000080);
        load_case("lb_a1", 3'b000, 2'd1, 32'h0000007F);
        load_case("lh_a2", 3'b001, 2'd2, 32'hFFFF80FF);
        load_case("lhu_a0", 3'b101, 2'd0, 32'h00007F01);
        load_case("lw", 3'b010, 2'd0, 32'h80FF7F01);
        load_case("f3_110", 3'b110, 2'd0, 32'h80FF7F01);

        // PC+4 wrap and LUI
        drive(1'b1, 1'b1, 5'd1, 2'b10, 3'd0, 32'h0, 32'h0, 32'hFFFFFFFC, 32'h0);
        tick();
        check("pc4_wrap", 64'(write_data), 64'h0);
        drive(1'b1, 1'b1, 5'd2, 2'b11, 3'd0, 32'h0, 32'h0, 32'h0, 32'hABCDE000);
        tick();
        check("lui", 64'(write_data), 64'hABCDE000);
        drive(1'b0, 1'b0, 5'd0, 2'b00, 3'd0, 32'h0, 32'h0, 32'h0, 32'h0);
        tick();

        // Hold: A to rd=3 held while B waits upstream
        drive(1'b1, 1'b1, 5'd3, 2'b00, 3'd0, 32'hAAAA0003, 32'h0, 32'h0, 32'h0);
        tick();
        cnt_snap = m_cnt;
        hold = 1'b1;
        drive(1'b1, 1'b1, 5'd4, 2'b00, 3'd0, 32'hBBBB0004, 32'h0, 32'h0, 32'h0);
        repeat (3) begin
            tick();
            check("hold_ready", 64'(wb_ready), 64'd0);
            check("hold_we", 64'(write_enable), 64'd0);
            check("hold_instret", instret, cnt_snap);
        end
        hold = 1'b0;
        #1;
        check("unhold_we_a", 64'(write_enable), 64'd1);
        check("unhold_addr_a", 64'(write_addr), 64'd3);
        tick();
        drive(1'b0, 1'b0, 5'd0, 2'b00, 3'd0, 32'h0, 32'h0, 32'h0, 32'h0);
        check("unhold_we_b", 64'(write_enable), 64'd1);
        check("unhold_addr_b", 64'(write_addr), 64'd4);
        tick();
        check("unhold_instret", instret, cnt_snap + 64'd2);

        // Asynchronous reset between edges discards the pending write to x7
        drive(1'b1, 1'b1, 5'd7, 2'b00, 3'd0, 32'h77777777, 32'h0, 32'h0, 32'h0);
        tick();
        drive(1'b0, 1'b0, 5'd0, 2'b00, 3'd0, 32'h0, 32'h0, 32'h0, 32'h0);
        check("pre_rst_we", 64'(write_enable), 64'd1);
        #2;
        RST = 1'b1;
        #1;
        check("async_rst_we", 64'(write_enable), 64'd0);
        check("async_rst_instret", instret, 64'd0);
        model_reset();
        @(posedge CLK);
        #1;
        RST = 1'b0;
        repeat (2) tick();

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 3) != 0), 1'($urandom), 5'($urandom),
                  2'($urandom), 3'($urandom), $urandom, $urandom,
                  $urandom, $urandom);
            hold = ($urandom_range(0, 3) == 0);
            tick();
        end
        hold = 1'b0;
        drive(1'b0, 1'b0, 5'd0, 2'b00, 3'd0, 32'h0, 32'h0, 32'h0, 32'h0);
        repeat (2) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/writeback_stage.md
# writeback_stage

Final stage of the rv32i pipeline: latches the retiring instruction from the memory stage and formats load data (byte/halfword select with sign or zero extension). It selects the result source and drives the register file write port (`write_enable`, `write_addr`, `write_data`). It also exposes the committed write for forwarding and counts retired instructions.

## Interface
Parameters:
- `DATA_WIDTH`, 32, datapath width
- `REG_ADDR_WIDTH`, 5, register index width
- `INSTRET_WIDTH`, 64, retired-instruction counter width

Ports:
- `CLK`  in  1  clock; all state updates on its rising edge
- `RST`  in  1  reset, asynchronous, active-high
- `mem_valid`  in  1  memory stage presents an instruction
- `wb_ready`  out  1  stage can accept an instruction this cycle
- `mem_reg_write`  in  1  instruction writes `rd`
- `mem_rd_addr`  in  REG_ADDR_WIDTH  destination register
- `mem_wb_sel`  in  2  result source: 00 ALU, 01 load, 10 PC+4, 11 immediate (LUI)
- `mem_funct3`  in  3  load width/sign code
- `mem_alu_result`  in  DATA_WIDTH  ALU result; also the load byte address
- `mem_load_data`  in  DATA_WIDTH  raw aligned 32-bit word from data memory
- `mem_pc`  in  DATA_WIDTH  instruction PC
- `mem_imm`  in  DATA_WIDTH  U-type immediate, already shifted
- `hold`  in  1  debug/stall request; freezes commit
- `write_enable`  out  1  register file write strobe
- `write_addr`  out  REG_ADDR_WIDTH  register file write index
- `write_data`  out  DATA_WIDTH  register file write value
- `fwd_valid`  out  1  `write_data` is valid for `write_addr` this cycle (forwarding)
- `instret`  out  INSTRET_WIDTH  count of committed instructions

## Operation
- One-entry holding register with fields `valid_q`, `reg_write_q`, `rd_q`, `result_q`.
- `result_q` is computed at capture:
  - ALU: `mem_alu_result`
  - PC+4: `mem_pc + 4`, modulo 2^32
  - Immediate: `mem_imm`
  - Load: formatted from `mem_load_data` using `a = mem_alu_result[1:0]` and `mem_funct3`:
    - 000 LB: byte `a`, sign-extended
    - 001 LH: halfword `a[1]`, sign-extended
    - 010 LW: full word
    - 100 LBU: byte `a`, zero-extended
    - 101 LHU: halfword `a[1]`, zero-extended
    - 011/110/111: full word
  - For halfword loads, `a[0]` is ignored; no misalignment trap in this block.
- Byte `n` is `mem_load_data[8n+7:8n]` (little-endian).
- Commit: `commit = valid_q & ~hold`.
- `write_enable = commit & reg_write_q & (rd_q != 0)`. x0 is never written, but the instruction still retires.
- `write_addr = rd_q`, `write_data = result_q`. Both are driven from registers at all times.
- `fwd_valid = write_enable`.
- `wb_ready = ~valid_q | ~hold`.
- Capture: when `mem_valid & wb_ready`, load all fields and set `valid_q`. Otherwise, if `commit`, clear `valid_q`. Otherwise hold all state.
- `instret` increments by 1 on every `commit` and wraps modulo 2^INSTRET_WIDTH.

## Timing
- Reset: `valid_q`=0, `reg_write_q`=0, `rd_q`=0, `result_q`=0, `instret`=0. Consequently `write_enable`=0, `fwd_valid`=0, `write_addr`=0, `write_data`=0, `wb_ready`=1.
- Reset asserted mid-operation discards any held entry immediately (asynchronously); no write occurs.
- Latency: an instruction captured at edge N is written by the register file at edge N+1 (`write_enable` is high during cycle N..N+1), provided `hold`=0.
- Back-to-back: with `hold`=0, one instruction is accepted and one committed per cycle; commit and capture at the same edge are legal.
- `hold`=1 with `valid_q`=1: `wb_ready`=0, `write_enable`=0, entry and `instret` frozen; upstream must keep its inputs stable.
- `hold`=1 with `valid_q`=0: capture still allowed, but the captured entry does not commit until `hold` falls.
- `write_enable`, `fwd_valid` and `wb_ready` are combinational from `valid_q`, `reg_write_q`, `rd_q` and `hold` only. There is no combinational path from any `mem_*` input.
- `instret` at all-ones plus one commit becomes 0.

## Test plan
- Reset then idle: assert `RST` for 2 cycles -> all outputs 0, `wb_ready`=1; then `mem_valid`=0 for 5 cycles -> `write_enable` stays 0, `instret`=0.
- ALU, then x0: ALU result 0x12345678 to rd=5 -> next cycle `write_enable`=1, `write_addr`=5, `write_data`=0x12345678, `instret`=1. Then same to rd=0 -> `write_enable`=0, `instret`=2.
- Load formats, `mem_load_data`=0x80FF7F01:
  - LB a=3 -> 0xFFFFFF80
  - LBU a=3 -> 0x00000080
  - LB a=1 -> 0x0000007F
  - LH a=2 -> 0xFFFF80FF
  - LHU a=0 -> 0x00007F01
  - LW -> 0x80FF7F01
  - funct3=110 -> 0x80FF7F01
- PC+4 and LUI: `mem_pc`=0xFFFFFFFC with sel 10 -> `write_data`=0x00000000. `mem_imm`=0xABCDE000 with sel 11 -> 0xABCDE000.
- Hold: capture instr A to rd=3, raise `hold` for 3 cycles while `mem_valid`=1 with instr B -> `wb_ready`=0, no write, `instret` unchanged. Drop `hold` -> A written, then B on the next cycle; `instret` +2.
- Async reset mid-op: capture a write to rd=7, assert `RST` between clock edges -> `write_enable` drops immediately, x7 is never written, `instret`=0.
